// File: rtl/l2_req_sched_pkg.sv
// Shared encodings for the L2 request scheduler: command, snoop, MESI, bus and FSM codes.
package l2_req_sched_pkg;

    typedef enum logic [1:0] {
        CMD_L1DR = 2'd0,
        CMD_L1DW = 2'd1,
        CMD_L1IR = 2'd2,
        CMD_SNP  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        SNP_SIREQ = 2'd0,
        SNP_SRREQ = 2'd1,
        SNP_SWREQ = 2'd2,
        SNP_SRFO  = 2'd3
    } snp_op_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [1:0] {
        BUS_READ  = 2'd0,
        BUS_RFO   = 2'd1,
        BUS_WRITE = 2'd2,
        BUS_INV   = 2'd3
    } bus_op_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'd0,
        SNP_HIT   = 2'd1,
        SNP_HITM  = 2'd2
    } snp_res_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_EVAL, ST_WB, ST_MISS, ST_INV, ST_UPD, ST_ACK
    } state_e;

endpackage

// File: rtl/l2_req_sched_rr_arb.sv
// 2-way round-robin arbiter (L1D/L1I) with an overriding priority requester (snoop).
module l2_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_pri,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_pri,
    output logic o_gnt_a,
    output logic o_gnt_b
);
    logic r_ptr_b;

    always_comb begin
        o_gnt_pri = i_en && i_req_pri;
        o_gnt_a   = i_en && !i_req_pri && i_req_a && (!i_req_b || !r_ptr_b);
        o_gnt_b   = i_en && !i_req_pri && i_req_b && (!i_req_a || r_ptr_b);
    end

    // Pointer favours the requester that was not granted last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_ptr_b <= 1'b0;
        else if (o_gnt_a) r_ptr_b <= 1'b1;
        else if (o_gnt_b) r_ptr_b <= 1'b0;
    end

endmodule

// File: rtl/l2_req_sched.sv
// L2 request scheduler: arbitrates L1D/L1I/snoop into the tag path and sequences hit, miss,
// victim writeback and snoop actions, keeping hit/read/write statistics.
module l2_req_sched
    import l2_req_sched_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int WAY_W    = 3,
    parameter int CNT_W    = 32,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               l1d_req,
    input  logic               l1d_we,
    input  logic [ADDR_W-1:0]  l1d_addr,
    output logic               l1d_ack,
    output logic               l1d_hit,
    input  logic               l1i_req,
    input  logic [ADDR_W-1:0]  l1i_addr,
    output logic               l1i_ack,
    output logic               l1i_hit,
    input  logic               snp_req,
    input  logic [1:0]         snp_op,
    input  logic [ADDR_W-1:0]  snp_addr,
    output logic               snp_ack,
    output logic [1:0]         snp_result,
    output logic               tag_lookup,
    output logic [INDEX_W-1:0] tag_index,
    output logic [TAG_W-1:0]   tag_tag,
    input  logic               tag_hit,
    input  logic [WAY_W-1:0]   tag_way,
    input  logic [1:0]         tag_mesi,
    input  logic [WAY_W-1:0]   vic_way,
    input  logic [TAG_W-1:0]   vic_tag,
    input  logic               vic_dirty,
    output logic               upd_en,
    output logic [WAY_W-1:0]   upd_way,
    output logic [1:0]         upd_mesi,
    output logic               lru_touch,
    output logic               bus_req,
    output logic [1:0]         bus_op,
    output logic [ADDR_W-1:0]  bus_addr,
    input  logic               bus_done,
    input  logic               bus_shared,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [CNT_W-1:0]   wr_cnt
);
    state_e              r_state;
    cmd_e                r_cmd;
    snp_op_e             r_snp_op;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_hit;
    snp_res_e            r_snp_hold, r_snp_result;
    logic                r_tag_lookup, r_upd_en, r_lru_touch;
    logic [WAY_W-1:0]    r_upd_way;
    mesi_e               r_upd_mesi;
    logic                r_bus_req;
    bus_op_e             r_bus_op;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic                r_l1d_ack, r_l1d_hit, r_l1i_ack, r_l1i_hit, r_snp_ack;
    logic [CNT_W-1:0]    r_hit_cnt, r_rd_cnt, r_wr_cnt;

    logic                w_gnt_snp, w_gnt_d, w_gnt_i;
    logic                w_valid, w_do_upd, w_hit;
    mesi_e               w_tag_mesi, w_mesi;
    state_e              w_next;
    logic [WAY_W-1:0]    w_way;
    snp_res_e            w_sres;
    bus_op_e             w_bus_op;
    logic [ADDR_W-1:0]   w_bus_addr, w_line_addr, w_vic_addr;
    logic                w_unused;

    l2_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == ST_IDLE),
        .i_req_pri (snp_req),
        .i_req_a   (l1d_req),
        .i_req_b   (l1i_req),
        .o_gnt_pri (w_gnt_snp),
        .o_gnt_a   (w_gnt_d),
        .o_gnt_b   (w_gnt_i)
    );

    assign w_line_addr = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign w_vic_addr  = {vic_tag, r_addr[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
    assign w_tag_mesi  = mesi_e'(tag_mesi);
    assign w_valid     = tag_hit && (w_tag_mesi != MESI_I);
    assign w_unused    = ^r_addr[OFFSET_W-1:0];

    // Lookup-result decode, consumed only in EVAL.
    always_comb begin
        w_next     = ST_UPD;
        w_do_upd   = 1'b1;
        w_way      = tag_way;
        w_mesi     = w_tag_mesi;
        w_hit      = w_valid;
        w_sres     = SNP_NOHIT;
        w_bus_op   = BUS_READ;
        w_bus_addr = w_line_addr;
        if (r_cmd == CMD_SNP) begin
            w_hit = 1'b0;
            if (!w_valid) begin
                w_do_upd = 1'b0;
            end else begin
                w_sres = SNP_HIT;
                case (r_snp_op)
                    SNP_SRREQ, SNP_SRFO: begin
                        w_mesi = (r_snp_op == SNP_SRREQ) ? MESI_S : MESI_I;
                        if (w_tag_mesi == MESI_M) begin
                            w_sres   = SNP_HITM;
                            w_next   = ST_WB;
                            w_bus_op = BUS_WRITE;
                        end
                    end
                    SNP_SIREQ: w_mesi = MESI_I;
                    default:   w_do_upd = 1'b0;
                endcase
            end
        end else if (w_valid) begin
            if (r_cmd == CMD_L1DW) begin
                w_mesi = MESI_M;
                if (w_tag_mesi == MESI_S) begin
                    w_next   = ST_INV;
                    w_bus_op = BUS_INV;
                end
            end
        end else begin
            w_way  = vic_way;
            w_mesi = (r_cmd == CMD_L1DW) ? MESI_M : MESI_E;
            if (vic_dirty) begin
                w_next     = ST_WB;
                w_bus_op   = BUS_WRITE;
                w_bus_addr = w_vic_addr;
            end else begin
                w_next   = ST_MISS;
                w_bus_op = (r_cmd == CMD_L1DW) ? BUS_RFO : BUS_READ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cmd        <= CMD_L1DR;
            r_snp_op     <= SNP_SIREQ;
            r_addr       <= '0;
            r_hit        <= 1'b0;
            r_snp_hold   <= SNP_NOHIT;
            r_snp_result <= SNP_NOHIT;
            r_tag_lookup <= 1'b0;
            r_upd_en     <= 1'b0;
            r_lru_touch  <= 1'b0;
            r_upd_way    <= '0;
            r_upd_mesi   <= MESI_I;
            r_bus_req    <= 1'b0;
            r_bus_op     <= BUS_READ;
            r_bus_addr   <= '0;
            r_l1d_ack    <= 1'b0;
            r_l1d_hit    <= 1'b0;
            r_l1i_ack    <= 1'b0;
            r_l1i_hit    <= 1'b0;
            r_snp_ack    <= 1'b0;
            r_hit_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
        end else begin
            r_tag_lookup <= 1'b0;
            r_upd_en     <= 1'b0;
            r_lru_touch  <= 1'b0;
            r_l1d_ack    <= 1'b0;
            r_l1d_hit    <= 1'b0;
            r_l1i_ack    <= 1'b0;
            r_l1i_hit    <= 1'b0;
            r_snp_ack    <= 1'b0;
            r_snp_result <= SNP_NOHIT;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_snp || w_gnt_d || w_gnt_i) begin
                        r_state      <= ST_LOOKUP;
                        r_tag_lookup <= 1'b1;
                    end
                    if (w_gnt_snp) begin
                        r_cmd    <= CMD_SNP;
                        r_snp_op <= snp_op_e'(snp_op);
                        r_addr   <= snp_addr;
                    end else if (w_gnt_d) begin
                        r_cmd  <= l1d_we ? CMD_L1DW : CMD_L1DR;
                        r_addr <= l1d_addr;
                    end else if (w_gnt_i) begin
                        r_cmd  <= CMD_L1IR;
                        r_addr <= l1i_addr;
                    end
                end
                ST_LOOKUP: r_state <= ST_EVAL;
                ST_EVAL: begin
                    r_state    <= w_next;
                    r_hit      <= w_hit;
                    r_snp_hold <= w_sres;
                    r_upd_way  <= w_way;
                    r_upd_mesi <= w_mesi;
                    r_bus_op   <= w_bus_op;
                    r_bus_addr <= w_bus_addr;
                    if (w_next == ST_UPD) begin
                        r_upd_en    <= w_do_upd;
                        r_lru_touch <= w_do_upd && (r_cmd != CMD_SNP);
                    end
                end
                // bus_req rises one cycle after op/addr settle and drops between chained ops.
                ST_WB, ST_MISS, ST_INV: begin
                    if (!r_bus_req) begin
                        r_bus_req <= 1'b1;
                    end else if (bus_done) begin
                        r_bus_req <= 1'b0;
                        if (r_state == ST_WB && r_cmd != CMD_SNP) begin
                            r_state    <= ST_MISS;
                            r_bus_op   <= (r_cmd == CMD_L1DW) ? BUS_RFO : BUS_READ;
                            r_bus_addr <= w_line_addr;
                        end else begin
                            r_state     <= ST_UPD;
                            r_upd_en    <= 1'b1;
                            r_lru_touch <= (r_cmd != CMD_SNP);
                            if (r_state == ST_MISS && r_cmd != CMD_L1DW)
                                r_upd_mesi <= bus_shared ? MESI_S : MESI_E;
                        end
                    end
                end
                ST_UPD: begin
                    r_state <= ST_ACK;
                    case (r_cmd)
                        CMD_SNP: begin
                            r_snp_ack    <= 1'b1;
                            r_snp_result <= r_snp_hold;
                        end
                        CMD_L1IR: begin
                            r_l1i_ack <= 1'b1;
                            r_l1i_hit <= r_hit;
                        end
                        default: begin
                            r_l1d_ack <= 1'b1;
                            r_l1d_hit <= r_hit;
                        end
                    endcase
                    if (r_cmd != CMD_SNP) begin
                        if (r_cmd == CMD_L1DW) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        else                   r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                        if (r_hit)             r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign l1d_ack    = r_l1d_ack;
    assign l1d_hit    = r_l1d_hit;
    assign l1i_ack    = r_l1i_ack;
    assign l1i_hit    = r_l1i_hit;
    assign snp_ack    = r_snp_ack;
    assign snp_result = r_snp_result;
    assign tag_lookup = r_tag_lookup;
    assign tag_index  = r_addr[OFFSET_W +: INDEX_W];
    assign tag_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign upd_en     = r_upd_en;
    assign upd_way    = r_upd_way;
    assign upd_mesi   = r_upd_mesi;
    assign lru_touch  = r_lru_touch;
    assign bus_req    = r_bus_req;
    assign bus_op     = r_bus_op;
    assign bus_addr   = r_bus_addr;
    assign hit_cnt    = r_hit_cnt;
    assign rd_cnt     = r_rd_cnt;
    assign wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_l2_req_sched.sv
// Directed bench for l2_req_sched: hand-computed expectations checked with immediate assertions.
module tb_l2_req_sched;
    localparam int ADDR_W = 32, OFFSET_W = 6, INDEX_W = 14, WAY_W = 3, CNT_W = 32;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;

    logic               clk = 1'b0, rst_n = 1'b0;
    logic               l1d_req = 0, l1d_we = 0, l1i_req = 0, snp_req = 0;
    logic [ADDR_W-1:0]  l1d_addr = '0, l1i_addr = '0, snp_addr = '0;
    logic [1:0]         snp_op = '0, tag_mesi = '0;
    logic               tag_hit = 0, vic_dirty = 0, bus_done = 0, bus_shared = 0;
    logic [WAY_W-1:0]   tag_way = '0, vic_way = '0;
    logic [TAG_W-1:0]   vic_tag = '0;
    logic               l1d_ack, l1d_hit, l1i_ack, l1i_hit, snp_ack, tag_lookup;
    logic               upd_en, lru_touch, bus_req;
    logic [1:0]         snp_result, upd_mesi, bus_op;
    logic [INDEX_W-1:0] tag_index;
    logic [TAG_W-1:0]   tag_tag;
    logic [WAY_W-1:0]   upd_way;
    logic [ADDR_W-1:0]  bus_addr;
    logic [CNT_W-1:0]   hit_cnt, rd_cnt, wr_cnt;

    l2_req_sched #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                   .WAY_W(WAY_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .l1d_req(l1d_req), .l1d_we(l1d_we), .l1d_addr(l1d_addr), .l1d_ack(l1d_ack), .l1d_hit(l1d_hit),
        .l1i_req(l1i_req), .l1i_addr(l1i_addr), .l1i_ack(l1i_ack), .l1i_hit(l1i_hit),
        .snp_req(snp_req), .snp_op(snp_op), .snp_addr(snp_addr), .snp_ack(snp_ack), .snp_result(snp_result),
        .tag_lookup(tag_lookup), .tag_index(tag_index), .tag_tag(tag_tag),
        .tag_hit(tag_hit), .tag_way(tag_way), .tag_mesi(tag_mesi),
        .vic_way(vic_way), .vic_tag(vic_tag), .vic_dirty(vic_dirty),
        .upd_en(upd_en), .upd_way(upd_way), .upd_mesi(upd_mesi), .lru_touch(lru_touch),
        .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr), .bus_done(bus_done), .bus_shared(bus_shared),
        .hit_cnt(hit_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_acks = 0, n_buscyc = 0;

    always @(negedge clk) begin
        if (l1d_ack || l1i_ack || snp_ack) n_acks++;
        if (bus_req) n_buscyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                            input logic shared, input string tag);
        int n = 0;
        while (!bus_req && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_req"}, bus_req, 1);
        if (bus_req) begin
            chk({tag, "_op"}, bus_op, op);
            chk({tag, "_addr"}, bus_addr, addr);
            @(negedge clk);
            chk({tag, "_stable"}, {bus_req, bus_op, bus_addr}, {1'b1, op, addr});
            bus_done = 1'b1; bus_shared = shared;
            @(negedge clk);
            bus_done = 1'b0; bus_shared = 1'b0;
        end
    endtask

    task automatic wait_upd(input logic [WAY_W-1:0] way, input logic [1:0] mesi,
                            input logic lru, input string tag, output int n);
        n = 0;
        while (!upd_en && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_en"}, upd_en, 1);
        chk({tag, "_way"}, upd_way, way);
        chk({tag, "_mesi"}, upd_mesi, mesi);
        chk({tag, "_lru"}, lru_touch, lru);
    endtask

    task automatic wait_ack_d(input logic hit, input string tag, output int n);
        n = 0;
        while (!l1d_ack && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ack"}, l1d_ack, 1);
        chk({tag, "_hit"}, l1d_hit, hit);
        l1d_req = 1'b0;
    endtask

    initial begin
        int n, n1, snap;
        int k;
        int order[3];
        logic [1:0] sres_seen;
        logic d_hit_seen, i_hit_seen;

        repeat (3) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_lookup", tag_lookup, 0);
        chk("rst_acks", {l1d_ack, l1i_ack, snp_ack, upd_en}, 0);
        chk("rst_cnts", {hit_cnt, rd_cnt, wr_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: L1DR miss, clean victim, READ not shared -> E
        tag_hit = 0; vic_dirty = 0; vic_way = 3'd3; vic_tag = 12'h7;
        l1d_we = 0; l1d_addr = 32'h0000_1040; l1d_req = 1;
        @(negedge clk);
        chk("t1_lookup", tag_lookup, 1);
        chk("t1_index", tag_index, 14'h41);
        chk("t1_tag", tag_tag, 12'h0);
        wait_bus(2'd0, 32'h0000_1040, 1'b0, "t1_rd");
        wait_upd(3'd3, 2'd2, 1'b1, "t1_upd", n);
        wait_ack_d(1'b0, "t1", n);
        chk("t1_rd_cnt", rd_cnt, 1);
        chk("t1_hit_cnt", hit_cnt, 0);
        @(negedge clk);

        // 2: L1DR hit on E, no bus traffic, ack 4 cycles after grant
        tag_hit = 1; tag_mesi = 2'd2; tag_way = 3'd5;
        snap = n_buscyc;
        l1d_req = 1;
        wait_upd(3'd5, 2'd2, 1'b1, "t2_upd", n1);
        wait_ack_d(1'b1, "t2", n);
        chk("t2_latency", n1 + n, 4);
        chk("t2_no_bus", n_buscyc - snap, 0);
        chk("t2_hit_cnt", hit_cnt, 1);
        chk("t2_rd_cnt", rd_cnt, 2);
        @(negedge clk);

        // 3: L1DW miss, dirty victim tag 0x5 -> WRITE back, RFO, M
        tag_hit = 0; vic_dirty = 1; vic_tag = 12'h005; vic_way = 3'd6;
        l1d_we = 1; l1d_addr = 32'h0123_45A4; l1d_req = 1;
        wait_bus(2'd2, 32'h0053_4580, 1'b0, "t3_wb");
        wait_bus(2'd1, 32'h0123_4580, 1'b0, "t3_rfo");
        wait_upd(3'd6, 2'd3, 1'b1, "t3_upd", n);
        wait_ack_d(1'b0, "t3", n);
        chk("t3_wr_cnt", wr_cnt, 1);
        chk("t3_cnts", {hit_cnt, rd_cnt}, {32'd1, 32'd2});
        @(negedge clk);

        // 4: fresh reset, then snoop + L1D + L1I together
        rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
        chk("t4_rst_cnts", {hit_cnt, rd_cnt, wr_cnt}, 0);
        tag_hit = 1; tag_mesi = 2'd2; tag_way = 3'd2; vic_dirty = 0;
        l1d_we = 0; snp_op = 2'd2; snp_addr = 32'h8000; l1d_addr = 32'h9000; l1i_addr = 32'hA000;
        snp_req = 1; l1d_req = 1; l1i_req = 1;
        k = 0; order = '{9, 9, 9}; sres_seen = 2'd3; d_hit_seen = 0; i_hit_seen = 0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clk);
            if (snp_ack) begin order[k] = 0; k++; sres_seen = snp_result; snp_req = 0; end
            if (l1d_ack) begin order[k] = 1; k++; d_hit_seen = l1d_hit; l1d_req = 0; end
            if (l1i_ack) begin order[k] = 2; k++; i_hit_seen = l1i_hit; l1i_req = 0; end
        end
        chk("t4_acks", k, 3);
        chk("t4_first_snp", order[0], 0);
        chk("t4_second_d", order[1], 1);
        chk("t4_third_i", order[2], 2);
        chk("t4_snp_res", sres_seen, 2'd1);
        chk("t4_l1_hits", {d_hit_seen, i_hit_seen}, 2'b11);
        chk("t4_cnts", {hit_cnt, rd_cnt, wr_cnt}, {32'd2, 32'd2, 32'd0});
        @(negedge clk);

        // 5: SRREQ hitting M -> HITM, writeback, S, no LRU touch
        tag_hit = 1; tag_mesi = 2'd3; tag_way = 3'd4;
        snp_op = 2'd1; snp_addr = 32'h0000_2010; snp_req = 1;
        wait_bus(2'd2, 32'h0000_2000, 1'b0, "t5_wb");
        wait_upd(3'd4, 2'd1, 1'b0, "t5_upd", n);
        n = 0;
        while (!snp_ack && n < 50) begin @(negedge clk); n++; end
        chk("t5_ack", snp_ack, 1);
        chk("t5_result", snp_result, 2'd2);
        snp_req = 0;
        chk("t5_rd_cnt", rd_cnt, 2);
        @(negedge clk);

        // 6: reset during writeback wait
        tag_hit = 0; vic_dirty = 1; vic_tag = 12'h001; vic_way = 3'd0;
        l1d_we = 1; l1d_addr = 32'h0000_4000; l1d_req = 1;
        n = 0;
        while (!bus_req && n < 50) begin @(negedge clk); n++; end
        chk("t6_bus_req_up", bus_req, 1);
        rst_n = 0; l1d_req = 0;
        #1;
        chk("t6_bus_req_async", bus_req, 0);
        @(negedge clk);
        rst_n = 1;
        snap = n_acks;
        repeat (10) @(negedge clk);
        chk("t6_no_ack", n_acks - snap, 0);
        chk("t6_bus_idle", bus_req, 0);
        chk("t6_cnts", {hit_cnt, rd_cnt, wr_cnt}, 0);
        tag_hit = 1; tag_mesi = 2'd1; tag_way = 3'd1;
        l1d_we = 0; l1d_addr = 32'h0000_4000; l1d_req = 1;
        wait_upd(3'd1, 2'd1, 1'b1, "t6_upd", n1);
        wait_ack_d(1'b1, "t6", n);
        chk("t6_idle_latency", n1 + n, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
